// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the RV32 datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_r1;
  logic [REG_ADDR_W-1:0] id_r2;
  logic                  id_use_r1;
  logic                  id_use_r2;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic                  idex_mem_re;
  logic                  ex_br_jmp_en;
  logic                  exmem_mem_re;
  logic                  exmem_mem_wr;
  logic                  dmem_ready;
  logic                  imem_ready;
  logic                  cnt_clr;
  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  mem_busy_o;
  logic [CNT_W-1:0]      stall_cycles_o;
  logic [CNT_W-1:0]      flush_events_o;

  modport master (
    output id_r1, id_r2, id_use_r1, id_use_r2, idex_rd, idex_mem_re, ex_br_jmp_en,
           exmem_mem_re, exmem_mem_wr, dmem_ready, imem_ready, cnt_clr,
    input  stall_o, flush_o, mem_busy_o, stall_cycles_o, flush_events_o
  );

  modport slave (
    input  id_r1, id_r2, id_use_r1, id_use_r2, idex_rd, idex_mem_re, ex_br_jmp_en,
           exmem_mem_re, exmem_mem_wr, dmem_ready, imem_ready, cnt_clr,
    output stall_o, flush_o, mem_busy_o, stall_cycles_o, flush_events_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generator for the 5-stage RV32 pipeline: load-use, branch, fetch wait, data-memory wait.
// Outputs are combinational from inputs plus WAIT state (zero added latency); dmem wait holds until released.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int DMEM_LAT   = 2,
  parameter int USE_READY  = 0,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int LAT_W = (DMEM_LAT > 2) ? $clog2(DMEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((DMEM_LAT > 0) ? DMEM_LAT - 1 : 0);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                state, state_nxt;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_nxt;
  logic [REG_ADDR_W-1:0] rd;
  logic                  acc, lu, memwait, br_flush;
  logic [NUM_STAGES-1:0] stall, flush;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  assign rd  = bus.idex_rd;
  assign acc = bus.exmem_mem_re | bus.exmem_mem_wr;
  assign lu  = bus.idex_mem_re && (rd != '0) &&
               ((bus.id_use_r1 && (bus.id_r1 == rd)) || (bus.id_use_r2 && (bus.id_r2 == rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    memwait     = 1'b0;
    if (USE_READY != 0) begin
      case (state)
        ST_IDLE: if (acc && !bus.dmem_ready) begin
          memwait   = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          memwait = !bus.dmem_ready;
          if (bus.dmem_ready) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (DMEM_LAT != 0) begin
      // The release cycle (lat_cnt==0) lets the access advance, so each access pays exactly DMEM_LAT.
      case (state)
        ST_IDLE: if (acc) begin
          memwait     = 1'b1;
          lat_cnt_nxt = LAT_LOAD;
          state_nxt   = ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt != '0) begin
            memwait     = 1'b1;
            lat_cnt_nxt = lat_cnt - 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A branch seen during a memory wait stays pending in the frozen EX stage and flushes on release.
  always_comb begin
    stall    = '0;
    flush    = '0;
    br_flush = 1'b0;
    if (rst) begin
      stall = '0;
    end else if (memwait) begin
      stall[3:0] = 4'b1111;
      flush[4]   = 1'b1;
    end else if (bus.ex_br_jmp_en) begin
      flush[2:1] = 2'b11;
      br_flush   = 1'b1;
    end else if (lu) begin
      stall[1:0] = 2'b11;
      flush[2]   = 1'b1;
    end else if (!bus.imem_ready) begin
      stall[0] = 1'b1;
      flush[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.cnt_clr)      stall_cnt <= '0;
      else if (stall != '0) stall_cnt <= stall_cnt + 1'b1;
      if (bus.cnt_clr)      flush_cnt <= '0;
      else if (br_flush)    flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;
  assign bus.mem_busy_o     = (state == ST_WAIT) && !rst;
  assign bus.stall_cycles_o = stall_cnt;
  assign bus.flush_events_o = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controller instances (fixed latency 3, ready handshake, fixed latency 2) share one stimulus.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(5), .REG_ADDR_W(5), .CNT_W(32)) bus3 ();
  pipe_hazard_ctrl_if #(.NUM_STAGES(5), .REG_ADDR_W(5), .CNT_W(32)) busr ();
  pipe_hazard_ctrl_if #(.NUM_STAGES(5), .REG_ADDR_W(5), .CNT_W(32)) bus2 ();

  pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .DMEM_LAT(3), .USE_READY(0), .CNT_W(32))
    u_lat3 (.clk(clk), .rst(rst), .bus(bus3));
  pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .DMEM_LAT(2), .USE_READY(1), .CNT_W(32))
    u_rdy (.clk(clk), .rst(rst), .bus(busr));
  pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .DMEM_LAT(2), .USE_READY(0), .CNT_W(32))
    u_lat2 (.clk(clk), .rst(rst), .bus(bus2));

  assign busr.id_r1 = bus3.id_r1;               assign bus2.id_r1 = bus3.id_r1;
  assign busr.id_r2 = bus3.id_r2;               assign bus2.id_r2 = bus3.id_r2;
  assign busr.id_use_r1 = bus3.id_use_r1;       assign bus2.id_use_r1 = bus3.id_use_r1;
  assign busr.id_use_r2 = bus3.id_use_r2;       assign bus2.id_use_r2 = bus3.id_use_r2;
  assign busr.idex_rd = bus3.idex_rd;           assign bus2.idex_rd = bus3.idex_rd;
  assign busr.idex_mem_re = bus3.idex_mem_re;   assign bus2.idex_mem_re = bus3.idex_mem_re;
  assign busr.ex_br_jmp_en = bus3.ex_br_jmp_en; assign bus2.ex_br_jmp_en = bus3.ex_br_jmp_en;
  assign busr.exmem_mem_re = bus3.exmem_mem_re; assign bus2.exmem_mem_re = bus3.exmem_mem_re;
  assign busr.exmem_mem_wr = bus3.exmem_mem_wr; assign bus2.exmem_mem_wr = bus3.exmem_mem_wr;
  assign busr.dmem_ready = bus3.dmem_ready;     assign bus2.dmem_ready = bus3.dmem_ready;
  assign busr.imem_ready = bus3.imem_ready;     assign bus2.imem_ready = bus3.imem_ready;
  assign busr.cnt_clr = bus3.cnt_clr;           assign bus2.cnt_clr = bus3.cnt_clr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus3.id_r1 = '0; bus3.id_r2 = '0; bus3.id_use_r1 = 1'b0; bus3.id_use_r2 = 1'b0;
    bus3.idex_rd = '0; bus3.idex_mem_re = 1'b0; bus3.ex_br_jmp_en = 1'b0;
    bus3.exmem_mem_re = 1'b0; bus3.exmem_mem_wr = 1'b0; bus3.dmem_ready = 1'b1;
    bus3.imem_ready = 1'b1; bus3.cnt_clr = 1'b0;
  endtask

  task automatic settle();
    idle();
    repeat (5) step();
  endtask

  task automatic clr();
    bus3.cnt_clr = 1'b1;
    step();
    bus3.cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus3.imem_ready = 1'b0;
    bus3.exmem_mem_re = 1'b1;
    #2;
    tests++; if (bus3.stall_o !== 5'b0) begin fails++; $display("FAIL reset_stall got %b want 00000", bus3.stall_o); end
    tests++; if (bus3.flush_o !== 5'b0) begin fails++; $display("FAIL reset_flush got %b want 00000", bus3.flush_o); end
    tests++; if (bus3.mem_busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus3.mem_busy_o); end
    tests++; if (bus3.stall_cycles_o !== 32'd0 || bus3.flush_events_o !== 32'd0) begin
      fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", bus3.stall_cycles_o, bus3.flush_events_o); end
    step();
    idle();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_load_use();
    bus3.idex_mem_re = 1'b1; bus3.idex_rd = 5'd5; bus3.id_r1 = 5'd5; bus3.id_use_r1 = 1'b1;
    #1;
    tests++; if (bus3.stall_o !== 5'b00011) begin fails++; $display("FAIL lu_rs1_stall got %b want 00011", bus3.stall_o); end
    tests++; if (bus3.flush_o !== 5'b00100) begin fails++; $display("FAIL lu_rs1_flush got %b want 00100", bus3.flush_o); end
    step();
    bus3.idex_mem_re = 1'b0;
    #1;
    tests++; if (bus3.stall_o !== 5'b0) begin fails++; $display("FAIL lu_one_cycle got %b want 00000", bus3.stall_o); end
    bus3.idex_mem_re = 1'b1; bus3.idex_rd = 5'd0; bus3.id_r1 = 5'd0;
    #1;
    tests++; if (bus3.stall_o !== 5'b0) begin fails++; $display("FAIL lu_x0 got %b want 00000", bus3.stall_o); end
    bus3.idex_rd = 5'd7; bus3.id_r1 = 5'd3; bus3.id_r2 = 5'd7; bus3.id_use_r2 = 1'b1;
    #1;
    tests++; if (bus3.stall_o !== 5'b00011) begin fails++; $display("FAIL lu_rs2 got %b want 00011", bus3.stall_o); end
    bus3.id_use_r2 = 1'b0;
    #1;
    tests++; if (bus3.stall_o !== 5'b0) begin fails++; $display("FAIL lu_unused_rs2 got %b want 00000", bus3.stall_o); end
    settle();
  endtask

  task automatic test_branch();
    clr();
    bus3.ex_br_jmp_en = 1'b1;
    #1;
    tests++; if (bus3.flush_o !== 5'b00110 || bus3.stall_o !== 5'b0) begin
      fails++; $display("FAIL branch got flush %b stall %b want 00110 00000", bus3.flush_o, bus3.stall_o); end
    step();
    bus3.ex_br_jmp_en = 1'b0;
    #1;
    tests++; if (bus3.flush_events_o !== 32'd1) begin fails++; $display("FAIL branch_count got %0d want 1", bus3.flush_events_o); end
    bus3.ex_br_jmp_en = 1'b1;
    bus3.idex_mem_re = 1'b1; bus3.idex_rd = 5'd9; bus3.id_r1 = 5'd9; bus3.id_use_r1 = 1'b1;
    bus3.imem_ready = 1'b0;
    #1;
    tests++; if (bus3.flush_o !== 5'b00110 || bus3.stall_o !== 5'b0) begin
      fails++; $display("FAIL branch_over_lu got flush %b stall %b want 00110 00000", bus3.flush_o, bus3.stall_o); end
    step();
    idle();
    #1;
    tests++; if (bus3.flush_events_o !== 32'd2 || bus3.stall_cycles_o !== 32'd0) begin
      fails++; $display("FAIL branch_counts got %0d/%0d want 2/0", bus3.flush_events_o, bus3.stall_cycles_o); end
    settle();
  endtask

  task automatic test_fixed_lat();
    logic [4:0] es, ef;
    logic       eb;
    clr();
    bus3.exmem_mem_re = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      es = (c < 3) ? 5'b01111 : 5'b00000;
      ef = (c < 3) ? 5'b10000 : 5'b00000;
      eb = (c >= 1);
      tests++; if (bus3.stall_o !== es || bus3.flush_o !== ef || bus3.mem_busy_o !== eb) begin
        fails++; $display("FAIL lat3_c%0d got stall %b flush %b busy %b want %b %b %b",
                          c, bus3.stall_o, bus3.flush_o, bus3.mem_busy_o, es, ef, eb); end
      step();
    end
    bus3.exmem_mem_re = 1'b0;
    #1;
    tests++; if (bus3.stall_cycles_o !== 32'd3 || bus3.mem_busy_o !== 1'b0) begin
      fails++; $display("FAIL lat3_total got %0d busy %b want 3 0", bus3.stall_cycles_o, bus3.mem_busy_o); end
    settle();
    clr();
    bus3.exmem_mem_re = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      es = ((c % 4) != 3) ? 5'b01111 : 5'b00000;
      tests++; if (bus3.stall_o !== es) begin
        fails++; $display("FAIL b2b_c%0d got %b want %b", c, bus3.stall_o, es); end
      if (c == 3) bus3.exmem_mem_re = 1'b0;
      if (c == 3) bus3.exmem_mem_wr = 1'b1;
      step();
    end
    bus3.exmem_mem_wr = 1'b0;
    #1;
    tests++; if (bus3.stall_cycles_o !== 32'd6) begin fails++; $display("FAIL b2b_total got %0d want 6", bus3.stall_cycles_o); end
    settle();
  endtask

  task automatic test_ready();
    logic [4:0] es;
    logic       eb;
    clr();
    bus3.exmem_mem_wr = 1'b1;
    bus3.dmem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) bus3.dmem_ready = 1'b1;
      #1;
      es = (c < 4) ? 5'b01111 : 5'b00000;
      eb = (c >= 1);
      tests++; if (busr.stall_o !== es || busr.mem_busy_o !== eb) begin
        fails++; $display("FAIL rdy_c%0d got stall %b busy %b want %b %b", c, busr.stall_o, busr.mem_busy_o, es, eb); end
      step();
    end
    bus3.exmem_mem_wr = 1'b0;
    #1;
    tests++; if (busr.stall_cycles_o !== 32'd4 || busr.mem_busy_o !== 1'b0) begin
      fails++; $display("FAIL rdy_total got %0d busy %b want 4 0", busr.stall_cycles_o, busr.mem_busy_o); end
    bus3.exmem_mem_re = 1'b1;
    #1;
    tests++; if (busr.stall_o !== 5'b0) begin fails++; $display("FAIL rdy_fast got %b want 00000", busr.stall_o); end
    step();
    bus3.exmem_mem_re = 1'b0;
    #1;
    tests++; if (busr.mem_busy_o !== 1'b0 || busr.stall_cycles_o !== 32'd4) begin
      fails++; $display("FAIL rdy_fast_after got busy %b cnt %0d want 0 4", busr.mem_busy_o, busr.stall_cycles_o); end
    settle();
  endtask

  task automatic test_branch_in_wait();
    logic [4:0] es, ef;
    clr();
    bus3.exmem_mem_re = 1'b1;
    bus3.ex_br_jmp_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      es = (c < 2) ? 5'b01111 : 5'b00000;
      ef = (c < 2) ? 5'b10000 : 5'b00110;
      tests++; if (bus2.stall_o !== es || bus2.flush_o !== ef) begin
        fails++; $display("FAIL brwait_c%0d got stall %b flush %b want %b %b", c, bus2.stall_o, bus2.flush_o, es, ef); end
      step();
    end
    idle();
    #1;
    tests++; if (bus2.flush_events_o !== 32'd1 || bus2.stall_cycles_o !== 32'd2) begin
      fails++; $display("FAIL brwait_counts got %0d/%0d want 1/2", bus2.flush_events_o, bus2.stall_cycles_o); end
    settle();
  endtask

  task automatic test_rst_mid_wait();
    bus3.exmem_mem_re = 1'b1;
    step();
    bus3.exmem_mem_re = 1'b0;
    #1;
    tests++; if (bus3.mem_busy_o !== 1'b1 || bus3.stall_o !== 5'b01111) begin
      fails++; $display("FAIL pre_rst got busy %b stall %b want 1 01111", bus3.mem_busy_o, bus3.stall_o); end
    rst = 1'b1;
    #1;
    tests++; if (bus3.stall_o !== 5'b0 || bus3.mem_busy_o !== 1'b0) begin
      fails++; $display("FAIL rst_mid_wait got stall %b busy %b want 00000 0", bus3.stall_o, bus3.mem_busy_o); end
    tests++; if (bus3.stall_cycles_o !== 32'd0 || bus3.flush_events_o !== 32'd0) begin
      fails++; $display("FAIL rst_counters got %0d/%0d want 0/0", bus3.stall_cycles_o, bus3.flush_events_o); end
    #2;
    rst = 1'b0;
    step();
    tests++; if (bus3.mem_busy_o !== 1'b0 || bus3.stall_o !== 5'b0) begin
      fails++; $display("FAIL post_rst got busy %b stall %b want 0 00000", bus3.mem_busy_o, bus3.stall_o); end
    settle();
  endtask

  task automatic test_imem();
    bus3.imem_ready = 1'b0;
    #1;
    tests++; if (bus3.stall_o !== 5'b00001 || bus3.flush_o !== 5'b00010) begin
      fails++; $display("FAIL imem got stall %b flush %b want 00001 00010", bus3.stall_o, bus3.flush_o); end
    bus3.idex_mem_re = 1'b1; bus3.idex_rd = 5'd12; bus3.id_r2 = 5'd12; bus3.id_use_r2 = 1'b1;
    #1;
    tests++; if (bus3.stall_o !== 5'b00011 || bus3.flush_o !== 5'b00100) begin
      fails++; $display("FAIL lu_over_imem got stall %b flush %b want 00011 00100", bus3.stall_o, bus3.flush_o); end
    settle();
  endtask

  task automatic test_cnt_clr();
    clr();
    bus3.ex_br_jmp_en = 1'b1;
    step();
    bus3.ex_br_jmp_en = 1'b0;
    bus3.imem_ready = 1'b0;
    step();
    step();
    bus3.imem_ready = 1'b1;
    #1;
    tests++; if (bus3.stall_cycles_o !== 32'd2 || bus3.flush_events_o !== 32'd1) begin
      fails++; $display("FAIL cnt_pre_clr got %0d/%0d want 2/1", bus3.stall_cycles_o, bus3.flush_events_o); end
    bus3.cnt_clr = 1'b1;
    bus3.imem_ready = 1'b0;
    bus3.ex_br_jmp_en = 1'b1;
    step();
    idle();
    #1;
    tests++; if (bus3.stall_cycles_o !== 32'd0 || bus3.flush_events_o !== 32'd0) begin
      fails++; $display("FAIL cnt_clr got %0d/%0d want 0/0", bus3.stall_cycles_o, bus3.flush_events_o); end
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_fixed_lat();
    test_ready();
    test_branch_in_wait();
    test_rst_mid_wait();
    test_imem();
    test_cnt_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline-control unit for the 5-stage RV32 core. It generates the StallBus and FlushBus vectors that are currently tied off or hand-wired at the top level.
- Covers load-use hazards, taken branch/jump flushes, instruction-fetch wait and multi-cycle data-memory accesses.
- Data-memory waits use either a fixed-latency counter or a ready handshake.
- Includes stall and flush performance counters.
- Bus bit order: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.

Parameters:
- NUM_STAGES, 5: width of stall_o/flush_o; must be ≥5; bits above 4 are driven 0.
- REG_ADDR_W, 5: register-address width.
- DMEM_LAT, 2: data-memory access latency in cycles when USE_READY=0; 0 = combinational memory, never stalls.
- USE_READY, 0: 1 = data-memory completion is signalled by dmem_ready; DMEM_LAT is then ignored.
- CNT_W, 32: performance counter width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- id_r1, in, REG_ADDR_W: rs1 of the instruction in ID.
- id_r2, in, REG_ADDR_W: rs2 of the instruction in ID.
- id_use_r1, in, 1: the ID instruction reads rs1.
- id_use_r2, in, 1: the ID instruction reads rs2.
- idex_rd, in, REG_ADDR_W: rd held in ID/EX.
- idex_mem_re, in, 1: the ID/EX instruction is a load.
- ex_br_jmp_en, in, 1: taken branch/jump resolved in EX.
- exmem_mem_re, in, 1: load in EX/MEM.
- exmem_mem_wr, in, 1: store in EX/MEM.
- dmem_ready, in, 1: data memory complete (used only when USE_READY=1).
- imem_ready, in, 1: fetch data valid this cycle.
- cnt_clr, in, 1: synchronous clear of the performance counters.
- stall_o, out, NUM_STAGES: per-stage hold.
- flush_o, out, NUM_STAGES: per-stage bubble insert.
- mem_busy_o, out, 1: data-memory FSM is in WAIT.
- stall_cycles_o, out, CNT_W: count of cycles with stall_o≠0.
- flush_events_o, out, CNT_W: count of cycles with a branch flush.

Behaviour:
- Reset (async): FSM to IDLE, latency counter 0, both perf counters 0. While rst=1, stall_o=0, flush_o=0 and mem_busy_o=0.
- stall_o and flush_o are combinational from the inputs plus registered FSM state. No added latency.

Hazard conditions:
- lu (load-use) = idex_mem_re & idex_rd≠0 & ((id_use_r1 & id_r1==idex_rd) | (id_use_r2 & id_r2==idex_rd)).
- acc = exmem_mem_re | exmem_mem_wr.

Data-memory FSM (IDLE, WAIT):
- DMEM_LAT=0 and USE_READY=0: FSM stays in IDLE and memwait is always 0.
- Fixed latency, IDLE with acc: memwait=1, load cnt=DMEM_LAT-1, go to WAIT.
- Fixed latency, WAIT: memwait=(cnt≠0); decrement cnt. When cnt==0, memwait=0, go to IDLE, and the instruction advances on that edge.
- Fixed latency result: exactly DMEM_LAT stall cycles per access, and back-to-back accesses each pay DMEM_LAT.
- Ready mode, IDLE: acc & !dmem_ready gives memwait=1 and goes to WAIT. acc & dmem_ready gives no stall and stays in IDLE.
- Ready mode, WAIT: memwait=!dmem_ready. dmem_ready=1 goes to IDLE.
- No timeout: dmem_ready stuck low holds the pipeline indefinitely.
- mem_busy_o = (state==WAIT).

Priority (first match wins):
1. memwait: stall[3:0]=1, flush[4]=1. The branch flush is suppressed; ex_br_jmp_en stays asserted because EX is frozen, so the flush is taken when the wait releases.
2. ex_br_jmp_en: flush[2:1]=1, stall=0. PC loads the target; lu and imem wait are ignored.
3. lu: stall[1:0]=1, flush[2]=1. imem wait is ignored because IF/ID is held.
4. !imem_ready: stall[0]=1, flush[1]=1.
5. Otherwise: stall_o=0, flush_o=0.

Counters:
- Both increment by 1 on qualifying cycles and wrap at 2^CNT_W.
- cnt_clr wins over increment: the counter is 0 on the next cycle.

Reset during WAIT: FSM returns to IDLE immediately and stall_o drops in the same cycle.

Test Plan:
1. Load-use: `lw x5` in ID/EX with idex_rd=5; ID has id_r1=5, id_use_r1=1 -> stall_o=00011, flush_o=00100 for exactly 1 cycle. Same with idex_rd=0 -> stall_o=0.
2. Branch: ex_br_jmp_en=1 for 1 cycle -> flush_o=00110, stall_o=0, flush_events_o increments 0→1. Combine with lu=1 -> branch result only.
3. Fixed latency DMEM_LAT=3: one acc -> stall_o=01111 and flush_o=10000 for 3 cycles, mem_busy_o=1 for 3 cycles, then release, stall_cycles_o=3. Two back-to-back accesses -> 6 stall cycles.
4. USE_READY=1: acc with dmem_ready low for 4 cycles then high -> 4 stall cycles; release in the dmem_ready cycle. acc with dmem_ready already high -> 0 stalls.
5. Branch during memwait: ex_br_jmp_en=1 throughout a DMEM_LAT=2 wait -> no flush during the wait; flush_o=00110 on the release cycle.
6. Async rst pulse mid-WAIT -> stall_o=0, mem_busy_o=0, counters=0 immediately. imem_ready=0 alone -> stall_o=00001, flush_o=00010. cnt_clr -> counters read 0 the next cycle.
